lsu_stage: RTL and testbench

Parametrised load/store pipeline stage between execute and writeback of the RV32/RV64 core. Replaces the single-cycle memory-access stage with a handshaked, variable-latency memory port, byte-lane alignment and byte enables, correct sign extension, misalignment detection and a bus timeout. Non-memory instructions pass through with one cycle of latency.

---
 rtl/rv_pkg.sv | 76 +++++++
 rtl/lsu_align.sv | 67 ++++++
 rtl/lsu_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32/RV64 decode definitions for the load/store stage.
// Holds the opcode and funct3 constants, the LSU FSM state type, the access
// width type and small decode helpers used by lsu_stage and lsu_align.
package rv_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] FN3_LB  = 3'b000;
   localparam logic [2:0] FN3_LH  = 3'b001;
   localparam logic [2:0] FN3_LW  = 3'b010;
   localparam logic [2:0] FN3_LD  = 3'b011;
   localparam logic [2:0] FN3_LBU = 3'b100;
   localparam logic [2:0] FN3_LHU = 3'b101;
   localparam logic [2:0] FN3_LWU = 3'b110;

   localparam logic [2:0] FN3_SB = 3'b000;
   localparam logic [2:0] FN3_SH = 3'b001;
   localparam logic [2:0] FN3_SW = 3'b010;
   localparam logic [2:0] FN3_SD = 3'b011;

   typedef enum logic [1:0] {StIdle, StReq, StWait} lsu_state_t;

   // Encoding matches funct3[1:0] of loads and stores.
   typedef enum logic [1:0] {WidthB, WidthH, WidthW, WidthD} width_t;

   function automatic width_t fn3_width(input logic [2:0] fn3);
      return width_t'(fn3[1:0]);
   endfunction

   function automatic logic is_misaligned(input width_t width, input logic [2:0] addr);
      logic mis;
      unique case (width)
         WidthB: mis = 1'b0;
         WidthH: mis = addr[0];
         WidthW: mis = |addr[1:0];
         WidthD: mis = |addr[2:0];
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   // Doubleword and LWU encodings exist only on RV64.
   function automatic logic mem_fn3_ok(input logic is_load, input logic [2:0] fn3,
                                       input logic wide);
      logic ok;
      if (is_load) begin
         unique case (fn3)
            FN3_LB, FN3_LH, FN3_LW, FN3_LBU, FN3_LHU: ok = 1'b1;
            FN3_LD, FN3_LWU:                          ok = wide;
            default:                                  ok = 1'b0;
         endcase
      end else begin
         unique case (fn3)
            FN3_SB, FN3_SH, FN3_SW: ok = 1'b1;
            FN3_SD:                 ok = wide;
            default:                ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic is_passthru(input logic [6:0] opc);
      return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
             (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
             (opc == OPC_SYSTEM);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store stage (purely combinational).
//   offset_i : byte offset of the access within the bus word
//   fn3_i    : load/store funct3 (width in [1:0], unsigned-load flag in [2])
//   wdata_i  : store data (rs2), rdata_i : raw bus read data
//   be_o     : store byte enables, wdata_o : store data replicated on all lanes
//   rdata_o  : load lane extracted from rdata_i and sign/zero extended
module lsu_align
   import rv_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   localparam int unsigned BEW = XLEN / 8,
   localparam int unsigned OFFW = $clog2(BEW)
) (
   input  logic [OFFW-1:0] offset_i,
   input  logic [2:0]      fn3_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [BEW-1:0]  be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   width_t          width;
   logic [XLEN-1:0] shifted;

   assign width = fn3_width(fn3_i);

   // Store side: the unit is replicated into every lane, enables pick the live lanes.
   always_comb begin
      be_o    = '0;
      wdata_o = '0;
      for (int i = 0; i < int'(BEW); i++) begin
         be_o[i] = (i >= int'(offset_i)) && (i < int'(offset_i) + (1 << int'(width)));
         unique case (width)
            WidthB: wdata_o[8*i +: 8] = wdata_i[7:0];
            WidthH: wdata_o[8*i +: 8] = wdata_i[8*(i%2) +: 8];
            WidthW: wdata_o[8*i +: 8] = wdata_i[8*(i%4) +: 8];
            WidthD: wdata_o[8*i +: 8] = wdata_i[8*i +: 8];
            default: wdata_o[8*i +: 8] = 8'h00;
         endcase
      end
   end

   assign shifted = rdata_i >> {offset_i, 3'b000};

   // Load side: fill with the sign bit unless the unsigned flag is set.
   always_comb begin
      rdata_o = '0;
      unique case (width)
         WidthB: begin
            rdata_o      = {XLEN{shifted[7] & ~fn3_i[2]}};
            rdata_o[7:0] = shifted[7:0];
         end
         WidthH: begin
            rdata_o       = {XLEN{shifted[15] & ~fn3_i[2]}};
            rdata_o[15:0] = shifted[15:0];
         end
         WidthW: begin
            rdata_o       = {XLEN{shifted[31] & ~fn3_i[2]}};
            rdata_o[31:0] = shifted[31:0];
         end
         WidthD: rdata_o = shifted;
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// Load/store pipeline stage between execute and writeback.
// Non-memory ops pass through in one cycle; aligned loads/stores go out on a
// req/gnt + rvalid bus; misaligned accesses and bus timeouts complete with a flag.
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_valid/o_ready             : execute handshake (i_instr, i_alu, i_rs2)
//   i_halt, i_taken_branch      : freeze acceptance, flush
//   o_mem_* / i_mem_*           : memory bus (request, grant, read response)
//   o_valid, o_instr, o_wb_data : one-cycle writeback pulse
//   o_misalign, o_err           : status, qualified by o_valid
module lsu_stage
   import rv_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_instr,
   input  logic [XLEN-1:0]   i_alu,
   input  logic [XLEN-1:0]   i_rs2,
   input  logic              i_halt,
   input  logic              i_taken_branch,
   output logic              o_mem_req,
   input  logic              i_mem_gnt,
   output logic              o_mem_we,
   output logic [XLEN-1:0]   o_mem_addr,
   output logic [XLEN/8-1:0] o_mem_be,
   output logic [XLEN-1:0]   o_mem_wdata,
   input  logic              i_mem_rvalid,
   input  logic [XLEN-1:0]   i_mem_rdata,
   output logic              o_valid,
   output logic [31:0]       o_instr,
   output logic [XLEN-1:0]   o_wb_data,
   output logic              o_misalign,
   output logic              o_err
);

   localparam int unsigned BEW  = XLEN / 8;
   localparam int unsigned OFFW = $clog2(BEW);
   localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

   lsu_state_t      state_q, state_d;
   logic [31:0]     txn_instr_q, txn_instr_d;
   logic [OFFW-1:0] off_q, off_d;
   logic            flushed_q, flushed_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            mem_we_q, mem_we_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [BEW-1:0]  mem_be_q, mem_be_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            misalign_q, misalign_d;
   logic            err_q, err_d;

   logic [6:0]      opc;
   logic [2:0]      fn3;
   logic            is_load, is_store, is_mem, misaligned, accept, timeout_hit;
   logic [OFFW-1:0] al_off;
   logic [2:0]      al_fn3;
   logic [BEW-1:0]  al_be;
   logic [XLEN-1:0] al_wdata, al_rdata;

   assign opc        = i_instr[6:0];
   assign fn3        = i_instr[14:12];
   assign is_load    = (opc == OPC_LOAD) && mem_fn3_ok(1'b1, fn3, XLEN == 64);
   assign is_store   = (opc == OPC_STORE) && mem_fn3_ok(1'b0, fn3, XLEN == 64);
   assign is_mem     = is_load || is_store;
   assign misaligned = is_misaligned(fn3_width(fn3), i_alu[2:0]);
   assign o_ready    = (state_q == StIdle) && !i_halt;
   assign accept     = i_valid && o_ready && !i_taken_branch;
   // >= rather than == so a grant taken on the last allowed cycle still times out in WAIT.
   assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT;

   // One aligner serves both directions: IDLE uses the incoming op, WAIT the held one.
   assign al_off = (state_q == StIdle) ? i_alu[OFFW-1:0] : off_q;
   assign al_fn3 = (state_q == StIdle) ? fn3 : txn_instr_q[14:12];

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .offset_i(al_off),
      .fn3_i   (al_fn3),
      .wdata_i (i_rs2),
      .rdata_i (i_mem_rdata),
      .be_o    (al_be),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

   always_comb begin
      state_d     = state_q;
      txn_instr_d = txn_instr_q;
      off_d       = off_q;
      flushed_d   = flushed_q;
      cnt_d       = cnt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = 1'b0;
      instr_d     = '0;
      wb_data_d   = '0;
      misalign_d  = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_mem && !misaligned) begin
                  state_d     = StReq;
                  txn_instr_d = i_instr;
                  off_d       = i_alu[OFFW-1:0];
                  flushed_d   = 1'b0;
                  cnt_d       = '0;
                  mem_we_d    = is_store;
                  mem_addr_d  = {i_alu[XLEN-1:OFFW], {OFFW{1'b0}}};
                  mem_be_d    = al_be;
                  mem_wdata_d = is_store ? al_wdata : '0;
               end else begin
                  valid_d    = 1'b1;
                  instr_d    = i_instr;
                  misalign_d = is_mem;
                  wb_data_d  = (!is_mem && is_passthru(opc)) ? i_alu : '0;
               end
            end
         end
         StReq: begin
            if (i_taken_branch) begin
               state_d = StIdle;
            end else if (i_mem_gnt) begin
               cnt_d = cnt_q + CNTW'(1);
               if (mem_we_q) begin
                  state_d = StIdle;
                  valid_d = 1'b1;
                  instr_d = txn_instr_q;
               end else begin
                  state_d = StWait;
               end
            end else if (timeout_hit) begin
               state_d = StIdle;
               valid_d = 1'b1;
               instr_d = txn_instr_q;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         StWait: begin
            if (i_mem_rvalid) begin
               state_d   = StIdle;
               valid_d   = !flushed_q;
               instr_d   = txn_instr_q;
               wb_data_d = al_rdata;
            end else if (timeout_hit) begin
               state_d = StIdle;
               valid_d = !flushed_q;
               instr_d = txn_instr_q;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
               if (i_taken_branch) flushed_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // A flush kills whatever pulse was decided this cycle; dead pulses carry no payload.
      if (i_taken_branch || !valid_d) begin
         valid_d    = 1'b0;
         instr_d    = '0;
         wb_data_d  = '0;
         misalign_d = 1'b0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         txn_instr_q <= '0;
         off_q       <= '0;
         flushed_q   <= 1'b0;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         valid_q     <= 1'b0;
         instr_q     <= '0;
         wb_data_q   <= '0;
         misalign_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         txn_instr_q <= txn_instr_d;
         off_q       <= off_d;
         flushed_q   <= flushed_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         instr_q     <= instr_d;
         wb_data_q   <= wb_data_d;
         misalign_q  <= misalign_d;
         err_q       <= err_d;
      end
   end

   assign o_mem_req   = (state_q == StReq);
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_be    = mem_be_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_valid     = valid_q;
   assign o_instr     = instr_q;
   assign o_wb_data   = wb_data_q;
   assign o_misalign  = misalign_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
   import rv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] wb;
      logic        mis;
      logic        err;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   // DUT A: XLEN=32, default timeout
   logic        a_rst, a_valid, a_ready, a_halt, a_br, a_req, a_gnt, a_we, a_rvalid;
   logic        a_ov, a_mis, a_err;
   logic [31:0] a_instr, a_alu, a_rs2, a_addr, a_wdata, a_rdata, a_oinstr, a_wb;
   logic [3:0]  a_be;
   // DUT B: XLEN=64, TIMEOUT=4
   logic        b_rst, b_valid, b_ready, b_halt, b_br, b_req, b_gnt, b_we, b_rvalid;
   logic        b_ov, b_mis, b_err;
   logic [31:0] b_instr, b_oinstr;
   logic [63:0] b_alu, b_rs2, b_addr, b_wdata, b_rdata, b_wb;
   logic [7:0]  b_be;

   lsu_stage #(.XLEN(32), .TIMEOUT(255)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_valid(a_valid), .o_ready(a_ready),
      .i_instr(a_instr), .i_alu(a_alu), .i_rs2(a_rs2), .i_halt(a_halt),
      .i_taken_branch(a_br), .o_mem_req(a_req), .i_mem_gnt(a_gnt), .o_mem_we(a_we),
      .o_mem_addr(a_addr), .o_mem_be(a_be), .o_mem_wdata(a_wdata),
      .i_mem_rvalid(a_rvalid), .i_mem_rdata(a_rdata), .o_valid(a_ov),
      .o_instr(a_oinstr), .o_wb_data(a_wb), .o_misalign(a_mis), .o_err(a_err)
   );

   lsu_stage #(.XLEN(64), .TIMEOUT(4)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_valid(b_valid), .o_ready(b_ready),
      .i_instr(b_instr), .i_alu(b_alu), .i_rs2(b_rs2), .i_halt(b_halt),
      .i_taken_branch(b_br), .o_mem_req(b_req), .i_mem_gnt(b_gnt), .o_mem_we(b_we),
      .o_mem_addr(b_addr), .o_mem_be(b_be), .o_mem_wdata(b_wdata),
      .i_mem_rvalid(b_rvalid), .i_mem_rdata(b_rdata), .o_valid(b_ov),
      .o_instr(b_oinstr), .o_wb_data(b_wb), .o_misalign(b_mis), .o_err(b_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [4:0] rd);
      return {17'h0, f3, rd, opc};
   endfunction

   function automatic exp_t mkexp(input logic [31:0] i, input logic [63:0] wb,
                                  input logic m, input logic e);
      exp_t t;
      t.instr = i;
      t.wb    = wb;
      t.mis   = m;
      t.err   = e;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_a(input logic [31:0] ins, input logic [31:0] alu,
                          input logic [31:0] rs2);
      a_valid = 1'b1; a_instr = ins; a_alu = alu; a_rs2 = rs2;
      step();
      a_valid = 1'b0;
   endtask

   task automatic issue_b(input logic [31:0] ins, input logic [63:0] alu,
                          input logic [63:0] rs2);
      b_valid = 1'b1; b_instr = ins; b_alu = alu; b_rs2 = rs2;
      step();
      b_valid = 1'b0;
   endtask

   // Monitors: pop one expected writeback per o_valid pulse.
   always @(negedge clk) begin
      if (!a_rst && a_ov) begin
         if (qa.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_valid: got instr %h expected no pulse", a_oinstr);
         end else begin
            ea = qa.pop_front();
            chk("a_instr", 64'(a_oinstr), 64'(ea.instr));
            chk("a_wb", 64'(a_wb), ea.wb);
            chk("a_misalign", 64'(a_mis), 64'(ea.mis));
            chk("a_err", 64'(a_err), 64'(ea.err));
         end
      end
   end

   always @(negedge clk) begin
      if (!b_rst && b_ov) begin
         if (qb.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_valid: got instr %h expected no pulse", b_oinstr);
         end else begin
            eb = qb.pop_front();
            chk("b_instr", 64'(b_oinstr), 64'(eb.instr));
            chk("b_wb", b_wb, eb.wb);
            chk("b_misalign", 64'(b_mis), 64'(eb.mis));
            chk("b_err", 64'(b_err), 64'(eb.err));
         end
      end
   end

   initial begin
      a_rst = 1; a_valid = 0; a_halt = 0; a_br = 0; a_gnt = 0; a_rvalid = 0;
      a_instr = 0; a_alu = 0; a_rs2 = 0; a_rdata = 0;
      b_rst = 1; b_valid = 0; b_halt = 0; b_br = 0; b_gnt = 0; b_rvalid = 0;
      b_instr = 0; b_alu = 0; b_rs2 = 0; b_rdata = 0;
      step();
      step();
      chk("rst_a_valid", 64'(a_ov), 0);
      chk("rst_a_req", 64'(a_req), 0);
      chk("rst_a_instr", 64'(a_oinstr), 0);
      chk("rst_a_wb", 64'(a_wb), 0);
      chk("rst_a_addr_be", {28'h0, a_be, a_addr}, 0);
      chk("rst_b_valid_req", {62'h0, b_ov, b_req}, 0);
      a_rst = 0; b_rst = 0;
      step();
      chk("a_ready_idle", 64'(a_ready), 1);

      // Back-to-back pass-through ops, then an unrecognised opcode.
      qa.push_back(mkexp(mk(OPC_OP, 3'd0, 5'd1), 64'h1111_2222, 0, 0));
      qa.push_back(mkexp(mk(OPC_OP_IMM, 3'd0, 5'd2), 64'h0000_0033, 0, 0));
      a_valid = 1; a_instr = mk(OPC_OP, 3'd0, 5'd1); a_alu = 32'h1111_2222;
      step();
      a_instr = mk(OPC_OP_IMM, 3'd0, 5'd2); a_alu = 32'h33;
      step();
      a_valid = 0;
      qa.push_back(mkexp(mk(7'b0001111, 3'd0, 5'd3), 64'h0, 0, 0));
      issue_a(mk(7'b0001111, 3'd0, 5'd3), 32'hDEAD, 0);
      step();

      // LB / LBU at 0x1003
      qa.push_back(mkexp(mk(OPC_LOAD, FN3_LB, 5'd4), 64'hFFFF_FF80, 0, 0));
      issue_a(mk(OPC_LOAD, FN3_LB, 5'd4), 32'h1003, 0);
      chk("lb_req", 64'(a_req), 1);
      chk("lb_addr", 64'(a_addr), 64'h1000);
      chk("lb_we", 64'(a_we), 0);
      chk("lb_ready_busy", 64'(a_ready), 0);
      a_gnt = 1; step(); a_gnt = 0;
      chk("lb_req_wait", 64'(a_req), 0);
      a_rvalid = 1; a_rdata = 32'h80FF_FF00; step(); a_rvalid = 0;
      step();
      qa.push_back(mkexp(mk(OPC_LOAD, FN3_LBU, 5'd5), 64'h0000_0080, 0, 0));
      issue_a(mk(OPC_LOAD, FN3_LBU, 5'd5), 32'h1003, 0);
      a_gnt = 1; step(); a_gnt = 0;
      a_rvalid = 1; a_rdata = 32'h80FF_FF00; step(); a_rvalid = 0;
      step();

      // SH at 0x2002
      qa.push_back(mkexp(mk(OPC_STORE, FN3_SH, 5'd0), 64'h0, 0, 0));
      issue_a(mk(OPC_STORE, FN3_SH, 5'd0), 32'h2002, 32'h1234_ABCD);
      chk("sh_be", 64'(a_be), 64'hC);
      chk("sh_wdata", 64'(a_wdata), 64'hABCD_ABCD);
      chk("sh_addr", 64'(a_addr), 64'h2000);
      chk("sh_we_req", {62'h0, a_we, a_req}, 64'h3);
      a_gnt = 1; step(); a_gnt = 0;
      step();

      // Misaligned LW and SW: no bus request.
      qa.push_back(mkexp(mk(OPC_LOAD, FN3_LW, 5'd6), 64'h0, 1, 0));
      issue_a(mk(OPC_LOAD, FN3_LW, 5'd6), 32'h3001, 0);
      chk("lw_mis_noreq", 64'(a_req), 0);
      qa.push_back(mkexp(mk(OPC_STORE, FN3_SW, 5'd0), 64'h0, 1, 0));
      issue_a(mk(OPC_STORE, FN3_SW, 5'd0), 32'h2002, 32'h5);
      chk("sw_mis_noreq", 64'(a_req), 0);
      step();

      // LW with grant after 3 cycles and rvalid 2 cycles after grant; halt mid-flight.
      qa.push_back(mkexp(mk(OPC_LOAD, FN3_LW, 5'd7), 64'hCAFE_F00D, 0, 0));
      issue_a(mk(OPC_LOAD, FN3_LW, 5'd7), 32'h4000, 0);
      for (int i = 0; i < 3; i++) begin
         chk("dly_req_held", 64'(a_req), 1);
         chk("dly_ready_low", 64'(a_ready), 0);
         step();
      end
      a_gnt = 1; step(); a_gnt = 0;
      a_halt = 1;
      chk("dly_wait_ready", 64'(a_ready), 0);
      step();
      a_rvalid = 1; a_rdata = 32'hCAFE_F00D;
      chk("dly_no_early_valid", 64'(a_ov), 0);
      step();
      a_rvalid = 0;
      chk("dly_valid_r_plus_1", 64'(a_ov), 1);
      chk("halt_ready_low", 64'(a_ready), 0);

      // Halt blocks acceptance until released.
      a_valid = 1; a_instr = mk(OPC_OP, 3'd0, 5'd8); a_alu = 32'h77;
      step();
      chk("halt_no_accept", 64'(a_ov), 0);
      qa.push_back(mkexp(mk(OPC_OP, 3'd0, 5'd8), 64'h77, 0, 0));
      a_halt = 0;
      step();
      a_valid = 0;
      step();

      // Flush in WAIT: later rvalid dropped, next ADD still completes.
      issue_a(mk(OPC_LOAD, FN3_LW, 5'd9), 32'h5000, 0);
      a_gnt = 1; step(); a_gnt = 0;
      a_br = 1; step(); a_br = 0;
      chk("flush_wait_ready", 64'(a_ready), 0);
      step();
      a_rvalid = 1; a_rdata = 32'h1234_5678; step(); a_rvalid = 0;
      chk("flush_wait_no_valid", 64'(a_ov), 0);
      chk("flush_wait_idle", 64'(a_ready), 1);
      qa.push_back(mkexp(mk(OPC_OP, 3'd0, 5'd10), 64'h5555, 0, 0));
      issue_a(mk(OPC_OP, 3'd0, 5'd10), 32'h5555, 0);
      step();

      // Flush in IDLE blocks capture.
      a_br = 1;
      issue_a(mk(OPC_OP, 3'd0, 5'd11), 32'h99, 0);
      a_br = 0;
      chk("flush_idle_no_valid", 64'(a_ov), 0);
      step();

      // Flush in REQ drops the request; a late rvalid in IDLE is ignored.
      issue_a(mk(OPC_LOAD, FN3_LW, 5'd12), 32'h6000, 0);
      a_br = 1; step(); a_br = 0;
      chk("flush_req_dropped", {62'h0, a_req, a_ready}, 64'h1);
      chk("flush_req_no_valid", 64'(a_ov), 0);
      a_rvalid = 1; step(); a_rvalid = 0;
      chk("late_rvalid_ignored", 64'(a_ov), 0);
      step();

      // XLEN=64: LWU / LW / LD lane extraction.
      qb.push_back(mkexp(mk(OPC_LOAD, FN3_LWU, 5'd1), 64'h0000_0000_FFFF_FFFF, 0, 0));
      issue_b(mk(OPC_LOAD, FN3_LWU, 5'd1), 64'h104, 0);
      chk("lwu_be", 64'(b_be), 64'hF0);
      chk("lwu_addr", b_addr, 64'h100);
      b_gnt = 1; step(); b_gnt = 0;
      b_rvalid = 1; b_rdata = 64'hFFFF_FFFF_0000_0000; step(); b_rvalid = 0;
      step();
      qb.push_back(mkexp(mk(OPC_LOAD, FN3_LW, 5'd2), 64'hFFFF_FFFF_FFFF_FFFF, 0, 0));
      issue_b(mk(OPC_LOAD, FN3_LW, 5'd2), 64'h104, 0);
      b_gnt = 1; step(); b_gnt = 0;
      b_rvalid = 1; b_rdata = 64'hFFFF_FFFF_0000_0000; step(); b_rvalid = 0;
      step();
      qb.push_back(mkexp(mk(OPC_LOAD, FN3_LD, 5'd3), 64'h0123_4567_89AB_CDEF, 0, 0));
      issue_b(mk(OPC_LOAD, FN3_LD, 5'd3), 64'h108, 0);
      chk("ld_be", 64'(b_be), 64'hFF);
      chk("ld_addr", b_addr, 64'h108);
      b_gnt = 1; step(); b_gnt = 0;
      b_rvalid = 1; b_rdata = 64'h0123_4567_89AB_CDEF; step(); b_rvalid = 0;
      step();

      // XLEN=64 stores.
      qb.push_back(mkexp(mk(OPC_STORE, FN3_SD, 5'd0), 64'h0, 0, 0));
      issue_b(mk(OPC_STORE, FN3_SD, 5'd0), 64'h110, 64'hA5A5_0000_1111_2222);
      chk("sd_wdata", b_wdata, 64'hA5A5_0000_1111_2222);
      chk("sd_be_we", {55'h0, b_we, b_be}, 64'h1FF);
      b_gnt = 1; step(); b_gnt = 0;
      step();
      qb.push_back(mkexp(mk(OPC_STORE, FN3_SB, 5'd0), 64'h0, 0, 0));
      issue_b(mk(OPC_STORE, FN3_SB, 5'd0), 64'h115, 64'h0000_0000_0000_045A);
      chk("sb_be", 64'(b_be), 64'h20);
      chk("sb_wdata", b_wdata, 64'h5A5A_5A5A_5A5A_5A5A);
      chk("sb_addr", b_addr, 64'h110);
      b_gnt = 1; step(); b_gnt = 0;
      step();

      // Misaligned LD (offset 4).
      qb.push_back(mkexp(mk(OPC_LOAD, FN3_LD, 5'd4), 64'h0, 1, 0));
      issue_b(mk(OPC_LOAD, FN3_LD, 5'd4), 64'h104, 0);
      chk("ld_mis_noreq", 64'(b_req), 0);
      step();

      // Timeout (TIMEOUT=4), grant never given.
      qb.push_back(mkexp(mk(OPC_LOAD, FN3_LW, 5'd5), 64'h0, 0, 1));
      issue_b(mk(OPC_LOAD, FN3_LW, 5'd5), 64'h200, 0);
      for (int i = 0; i < 4; i++) begin
         chk("to_req_held", 64'(b_req), 1);
         chk("to_no_early_valid", 64'(b_ov), 0);
         step();
      end
      chk("to_valid_5th", 64'(b_ov), 1);
      chk("to_req_dropped", 64'(b_req), 0);
      b_rvalid = 1; b_rdata = 64'h1; step(); b_rvalid = 0;
      chk("to_late_rvalid_ignored", 64'(b_ov), 0);

      repeat (3) step();
      chk("a_queue_drained", 64'(qa.size()), 0);
      chk("b_queue_drained", 64'(qb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
